// File: rtl/fpmul_seq.sv
// fpmul_seq: sequential IEEE-754 multiplier with a parameterised format.
// One multiplier bit is consumed per cycle by a shift-add datapath. The
// result is rounded to nearest-even. Subnormal inputs are flushed to zero.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   dataA, dataB        operands, captured on the accepting edge
//   out_valid/out_ready result handshake; result is held until retired
//   dataR               packed result
//   flags               {invalid, overflow, underflow, inexact}
module fpmul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   dataA,
    input  logic [EXP_W+MAN_W:0]   dataB,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   dataR,
    output logic [3:0]             flags
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int M    = MAN_W + 1;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int CW   = $clog2(M);
    localparam int EW   = EXP_W + 2;
    localparam int EMAX = (1 << EXP_W) - 1;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MULT, S_NORM, S_OUT} state_t;

    state_t           r_state;
    logic [W-1:0]     r_a, r_b;
    logic [2*M-1:0]   r_acc;
    logic [2*M-1:0]   r_mcand;
    logic [M-1:0]     r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic [W-1:0]     r_dataR;
    logic [3:0]       r_flags;

    // ---------------- operand unpack ----------------
    logic             w_sign;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic             w_a_snan, w_b_snan;

    assign w_sign   = r_a[W-1] ^ r_b[W-1];
    assign w_ea     = r_a[W-2 -: EXP_W];
    assign w_eb     = r_b[W-2 -: EXP_W];
    assign w_fa     = r_a[MAN_W-1:0];
    assign w_fb     = r_b[MAN_W-1:0];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (&w_ea) && (w_fa == '0);
    assign w_b_inf  = (&w_eb) && (w_fb == '0);
    assign w_a_nan  = (&w_ea) && (|w_fa);
    assign w_b_nan  = (&w_eb) && (|w_fb);
    assign w_a_snan = w_a_nan && !w_fa[MAN_W-1];
    assign w_b_snan = w_b_nan && !w_fb[MAN_W-1];

    // ---------------- special-case resolution ----------------
    logic             w_special;
    logic [W-1:0]     w_sp_res;
    logic [3:0]       w_sp_flags;

    always_comb begin
        w_special  = 1'b1;
        w_sp_res   = '0;
        w_sp_flags = '0;
        if (w_a_nan || w_b_nan) begin
            w_sp_res   = QNAN;
            w_sp_flags = {w_a_snan | w_b_snan, 3'b000};
        end else if ((w_a_zero && w_b_inf) || (w_a_inf && w_b_zero)) begin
            w_sp_res   = QNAN;
            w_sp_flags = 4'b1000;
        end else if (w_a_inf || w_b_inf) begin
            w_sp_res   = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_a_zero || w_b_zero) begin
            w_sp_res   = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_special  = 1'b0;
        end
    end

    // ---------------- normalise / round ----------------
    // Exponents are handled as two's complement in EW bits; the sign bit
    // flags underflow and the magnitude can never wrap for valid inputs.
    logic [EW-1:0]    w_e0, w_e1, w_e2;
    logic [MAN_W-1:0] w_frac, w_frac_r;
    logic [MAN_W:0]   w_fr_sum;
    logic             w_g, w_s, w_rup, w_ovf, w_udf;
    logic [W-1:0]     w_n_res;
    logic [3:0]       w_n_flags;

    assign w_e0 = EW'(w_ea) + EW'(w_eb) - EW'(BIAS);

    always_comb begin
        if (r_acc[2*M-1]) begin
            w_frac = r_acc[2*M-2 -: MAN_W];
            w_g    = r_acc[M-1];
            w_s    = |r_acc[M-2:0];
            w_e1   = w_e0 + EW'(1);
        end else begin
            w_frac = r_acc[2*M-3 -: MAN_W];
            w_g    = r_acc[M-2];
            w_s    = |r_acc[M-3:0];
            w_e1   = w_e0;
        end
    end

    assign w_rup    = w_g & (w_s | w_frac[0]);
    assign w_fr_sum = {1'b0, w_frac} + (MAN_W+1)'(w_rup);
    // A carry out of the fraction means the significand rolled to 2.0.
    assign w_frac_r = w_fr_sum[MAN_W] ? '0 : w_fr_sum[MAN_W-1:0];
    assign w_e2     = w_fr_sum[MAN_W] ? w_e1 + EW'(1) : w_e1;
    assign w_ovf    = !w_e2[EW-1] && (w_e2 >= EW'(EMAX));
    assign w_udf    = w_e2[EW-1] || (w_e2 == '0);

    always_comb begin
        if (w_ovf) begin
            w_n_res   = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_n_flags = 4'b0101;
        end else if (w_udf) begin
            w_n_res   = {w_sign, {(W-1){1'b0}}};
            w_n_flags = 4'b0011;
        end else begin
            w_n_res   = {w_sign, w_e2[EXP_W-1:0], w_frac_r};
            w_n_flags = {3'b000, w_g | w_s};
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_dataR     <= '0;
            r_flags     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= dataA;
                        r_b     <= dataB;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_special) begin
                        r_dataR     <= w_sp_res;
                        r_flags     <= w_sp_flags;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_acc    <= '0;
                        r_mcand  <= {{M{1'b0}}, 1'b1, w_fb};
                        r_mplier <= {1'b1, w_fa};
                        r_cnt    <= '0;
                        r_state  <= S_MULT;
                    end
                end
                S_MULT: begin
                    r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(M-1))
                        r_state <= S_NORM;
                end
                S_NORM: begin
                    r_dataR     <= w_n_res;
                    r_flags     <= w_n_flags;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign dataR     = r_dataR;
    assign flags     = r_flags;

endmodule

// File: tb/tb_fpmul_seq.sv
// Directed bench for fpmul_seq: single-precision instance plus a
// half-precision instance sharing clock and reset.
module tb_fpmul_seq;
    logic        clk = 1'b0;
    logic        reset;
    // single precision
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] dataA, dataB, dataR;
    logic [3:0]  flags;
    // half precision
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_dataA, h_dataB, h_dataR;
    logic [3:0]  h_flags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fpmul_seq #(.EXP_W(8), .MAN_W(23)) u_sp (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .dataA(dataA), .dataB(dataB),
        .out_valid(out_valid), .out_ready(out_ready),
        .dataR(dataR), .flags(flags)
    );

    fpmul_seq #(.EXP_W(5), .MAN_W(10)) u_hp (
        .clk(clk), .reset(reset),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .dataA(h_dataA), .dataB(h_dataB),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .dataR(h_dataR), .flags(h_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, measure latency, check result, optionally hold
    // out_ready low for 'hold' cycles, then retire and check in_ready.
    task automatic run(input string tag, input bit half,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef,
                       input int elat, input int hold);
        int lat;
        logic ov;
        logic [31:0] r0;
        @(negedge clk);
        if (half) begin
            h_in_valid = 1'b1; h_dataA = a[15:0]; h_dataB = b[15:0];
            chk({tag, "_rdy"}, {31'd0, h_in_ready}, 32'd1);
        end else begin
            in_valid = 1'b1; dataA = a; dataB = b;
            chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; h_in_valid = 1'b0;
        lat = 0;
        ov  = 1'b0;
        while (!ov && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            ov = half ? h_out_valid : out_valid;
        end
        chk({tag, "_lat"}, lat, elat);
        r0 = half ? {16'd0, h_dataR} : dataR;
        chk({tag, "_res"}, r0, er);
        chk({tag, "_flg"}, {28'd0, half ? h_flags : flags}, {28'd0, ef});
        for (int i = 0; i < hold; i++) begin
            // in_valid pulses with junk operands while busy must be ignored
            in_valid = 1'b1; dataA = 32'hDEADBEEF; dataB = 32'h12345678;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({tag, "_hold_res"}, half ? {16'd0, h_dataR} : dataR, r0);
            chk({tag, "_hold_vld"}, {31'd0, half ? h_out_valid : out_valid}, 32'd1);
            chk({tag, "_hold_rdy"}, {31'd0, half ? h_in_ready : in_ready}, 32'd0);
        end
        if (half) h_out_ready = 1'b1; else out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; h_out_ready = 1'b0;
        chk({tag, "_ret_vld"}, {31'd0, half ? h_out_valid : out_valid}, 32'd0);
        chk({tag, "_ret_rdy"}, {31'd0, half ? h_in_ready : in_ready}, 32'd1);
    endtask

    initial begin
        logic seen;
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; dataA = '0; dataB = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b0; h_dataA = '0; h_dataB = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld",  {31'd0, out_valid}, 32'd0);
        chk("rst_res",  dataR, 32'd0);
        chk("rst_flg",  {28'd0, flags}, 32'd0);
        chk("rst_hvld", {31'd0, h_out_valid}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_rdy",  {31'd0, in_ready}, 32'd1);

        run("round",  1'b0, 32'h41480000, 32'hC0A66666, 32'hC2820000, 4'b0001, 26, 0);
        run("exact",  1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26, 0);
        run("zxinf",  1'b0, 32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000, 1, 0);
        run("infxn",  1'b0, 32'h7F800000, 32'hBF800000, 32'hFF800000, 4'b0000, 1, 0);
        run("snan",   1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1, 0);
        run("qnan",   1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 1, 0);
        run("negz",   1'b0, 32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1, 0);
        run("ovf",    1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 26, 0);
        run("udf",    1'b0, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 26, 0);
        run("bp",     1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26, 5);

        // reset during MULT aborts the operation
        @(negedge clk);
        in_valid = 1'b1; dataA = 32'h3FC00000; dataB = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        chk("abort_vld", {31'd0, seen}, 32'd0);
        chk("abort_rdy", {31'd0, in_ready}, 32'd1);
        run("after", 1'b0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 26, 0);

        // half precision instance
        run("h_one", 1'b1, 32'h3C00, 32'h4000, 32'h4000, 4'b0000, 13, 0);
        run("h_ovf", 1'b1, 32'h7BFF, 32'h4000, 32'h7C00, 4'b0101, 13, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
